// File: rtl/vga_video_out.sv
// vga_video_out
// -----------------------------------------------------------------------------
// VGA output stage between a pixel source and the board DAC pins.
// Divides CLOCK_50 into a pixel-enable (pix_ce), runs programmable horizontal
// and vertical timing counters, publishes the current coordinate as a pixel
// request, and re-aligns the returned pixel data with sync and blank through a
// delay line matched to the source latency.
//
// Optional feature macro: VGA_TEST_PATTERN_EN
//   defined   -> adds input TEST_PATTERN; while high, the output stage shows
//                eight vertical colour bars instead of source data.
//   undefined -> no TEST_PATTERN port, output is always source data.
//
// Ports
//   CLOCK_50            in   sole clock
//   RESET_N             in   asynchronous, active-low reset
//   PIX_X / PIX_Y       out  current horizontal / vertical count
//   PIX_REQ             out  high while (PIX_X, PIX_Y) is inside the active area
//   PIX_R/G/B           in   source pixel data, PIX_LATENCY slots after request
//   TEST_PATTERN        in   colour-bar select (VGA_TEST_PATTERN_EN builds only)
//   FRAME_START         out  one-cycle pulse when the counters wrap to (0,0)
//   VGA_R/G/B           out  8-bit DAC colour
//   VGA_HS / VGA_VS     out  syncs, polarity set by HS_POL / VS_POL
//   VGA_BLANK_N         out  low outside active video
//   VGA_SYNC_N          out  constant 0
//   VGA_CLK             out  DAC pixel clock
// -----------------------------------------------------------------------------
module vga_video_out #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic HS_POL      = 1'b0,
  parameter logic VS_POL      = 1'b0,
  parameter int   CLK_DIV     = 2,
  parameter int   COLOR_BITS  = 8,
  parameter int   PIX_LATENCY = 2,
  localparam int  H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  XW          = $clog2(H_TOTAL),
  localparam int  YW          = $clog2(V_TOTAL)
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  output logic [XW-1:0]         PIX_X,
  output logic [YW-1:0]         PIX_Y,
  output logic                  PIX_REQ,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                  TEST_PATTERN,
`endif
  input  logic [COLOR_BITS-1:0] PIX_R,
  input  logic [COLOR_BITS-1:0] PIX_G,
  input  logic [COLOR_BITS-1:0] PIX_B,
  output logic                  FRAME_START,
  output logic [7:0]            VGA_R,
  output logic [7:0]            VGA_G,
  output logic [7:0]            VGA_B,
  output logic                  VGA_HS,
  output logic                  VGA_VS,
  output logic                  VGA_BLANK_N,
  output logic                  VGA_SYNC_N,
  output logic                  VGA_CLK
);

  localparam int DW = $clog2(CLK_DIV);

  // Timing boundaries sized to the counters; every one of them is below the
  // line/frame total, so the casts never truncate.
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF  = DW'(CLK_DIV / 2);
  localparam logic [XW-1:0] H_LAST    = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT_X   = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_START  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END    = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_LAST    = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT_Y   = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_START  = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END    = YW'(V_ACTIVE + V_FP + V_SYNC);

`ifdef VGA_TEST_PATTERN_EN
  localparam int DLW = 3 + XW;
`else
  localparam int DLW = 3;
`endif

  // Bit replication that MSB-aligns a COLOR_BITS channel to 8 bits, so full
  // scale in maps to full scale out (e.g. 3'b101 -> 8'hB6).
  function automatic logic [7:0] expand(input logic [COLOR_BITS-1:0] c);
    logic [7:0] e;
    for (int i = 0; i < 8; i++) begin
      e[7-i] = c[COLOR_BITS-1-(i % COLOR_BITS)];
    end
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Pixel-enable divider and timing counters
  // ---------------------------------------------------------------------------
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [XW-1:0] h_cnt_q, h_cnt_d;
  logic [YW-1:0] v_cnt_q, v_cnt_d;
  logic          frame_start_q, frame_start_d;
  logic          vga_clk_q, vga_clk_d;
  logic          pix_ce;
  logic          h_wrap;
  logic          v_wrap;
  logic          hsync_raw;
  logic          vsync_raw;

  assign pix_ce = (div_cnt_q == DIV_LAST);
  assign h_wrap = (h_cnt_q == H_LAST);
  assign v_wrap = (v_cnt_q == V_LAST);

  always_comb begin
    div_cnt_d     = pix_ce ? '0 : div_cnt_q + 1'b1;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    if (pix_ce) begin
      if (h_wrap) begin
        h_cnt_d = '0;
        v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
    frame_start_d = pix_ce && h_wrap && v_wrap;
    // Computed from the next divider value so the registered clock tracks
    // div_cnt without lag: it is low right after pix_ce, which keeps output
    // register updates away from the DAC's rising edge.
    vga_clk_d     = (div_cnt_d >= DIV_HALF);
  end

  assign PIX_REQ   = (h_cnt_q < H_ACT_X) && (v_cnt_q < V_ACT_Y);
  assign hsync_raw = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
  assign vsync_raw = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);

  // ---------------------------------------------------------------------------
  // Latency-matching delay line. PIX_LATENCY registers here plus the output
  // register give PIX_LATENCY+1 stages from request to pins.
  // ---------------------------------------------------------------------------
  logic [DLW-1:0] dly_in;
  logic [DLW-1:0] dly_out;

`ifdef VGA_TEST_PATTERN_EN
  assign dly_in = {h_cnt_q, PIX_REQ, vsync_raw, hsync_raw};
`else
  assign dly_in = {PIX_REQ, vsync_raw, hsync_raw};
`endif

  if (PIX_LATENCY == 0) begin : g_no_dly
    assign dly_out = dly_in;
  end else begin : g_dly
    logic [DLW-1:0] dly_q [PIX_LATENCY];
    logic [DLW-1:0] dly_d [PIX_LATENCY];

    always_comb begin
      for (int i = 0; i < PIX_LATENCY; i++) begin
        dly_d[i] = dly_q[i];
      end
      if (pix_ce) begin
        dly_d[0] = dly_in;
        for (int i = 1; i < PIX_LATENCY; i++) begin
          dly_d[i] = dly_q[i-1];
        end
      end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
        for (int i = 0; i < PIX_LATENCY; i++) begin
          dly_q[i] <= '0;
        end
      end else begin
        for (int i = 0; i < PIX_LATENCY; i++) begin
          dly_q[i] <= dly_d[i];
        end
      end
    end

    assign dly_out = dly_q[PIX_LATENCY-1];
  end

  logic hs_dly;
  logic vs_dly;
  logic req_dly;

  assign hs_dly  = dly_out[0];
  assign vs_dly  = dly_out[1];
  assign req_dly = dly_out[2];

`ifdef VGA_TEST_PATTERN_EN
  logic [XW-1:0] x_dly;
  logic [2:0]    bar;

  assign x_dly = dly_out[DLW-1:3];
  // x < H_ACTIVE whenever req_dly is set, so the bar index stays in 0..7.
  assign bar   = 3'((32'(x_dly) * 32'd8) / 32'(H_ACTIVE));
`endif

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  logic       vga_hs_q, vga_hs_d;
  logic       vga_vs_q, vga_vs_d;
  logic       vga_blank_n_q, vga_blank_n_d;
  logic [7:0] vga_r_q, vga_r_d;
  logic [7:0] vga_g_q, vga_g_d;
  logic [7:0] vga_b_q, vga_b_d;

  always_comb begin
    vga_hs_d      = vga_hs_q;
    vga_vs_d      = vga_vs_q;
    vga_blank_n_d = vga_blank_n_q;
    vga_r_d       = vga_r_q;
    vga_g_d       = vga_g_q;
    vga_b_d       = vga_b_q;
    if (pix_ce) begin
      vga_hs_d      = hs_dly ^ ~HS_POL;
      vga_vs_d      = vs_dly ^ ~VS_POL;
      vga_blank_n_d = req_dly;
      if (req_dly) begin
        vga_r_d = expand(PIX_R);
        vga_g_d = expand(PIX_G);
        vga_b_d = expand(PIX_B);
`ifdef VGA_TEST_PATTERN_EN
        // Bar order white, yellow, cyan, green, magenta, red, blue, black:
        // each channel is a single bit of the inverted bar index.
        if (TEST_PATTERN) begin
          vga_r_d = {8{~bar[1]}};
          vga_g_d = {8{~bar[2]}};
          vga_b_d = {8{~bar[0]}};
        end
`endif
      end else begin
        // Source data is ignored in blank slots, whatever its value.
        vga_r_d = 8'h00;
        vga_g_d = 8'h00;
        vga_b_d = 8'h00;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      div_cnt_q     <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_start_q <= 1'b0;
      vga_clk_q     <= 1'b0;
      vga_hs_q      <= ~HS_POL;
      vga_vs_q      <= ~VS_POL;
      vga_blank_n_q <= 1'b0;
      vga_r_q       <= 8'h00;
      vga_g_q       <= 8'h00;
      vga_b_q       <= 8'h00;
    end else begin
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_start_q <= frame_start_d;
      vga_clk_q     <= vga_clk_d;
      vga_hs_q      <= vga_hs_d;
      vga_vs_q      <= vga_vs_d;
      vga_blank_n_q <= vga_blank_n_d;
      vga_r_q       <= vga_r_d;
      vga_g_q       <= vga_g_d;
      vga_b_q       <= vga_b_d;
    end
  end

  assign PIX_X       = h_cnt_q;
  assign PIX_Y       = v_cnt_q;
  assign FRAME_START = frame_start_q;
  assign VGA_CLK     = vga_clk_q;
  assign VGA_HS      = vga_hs_q;
  assign VGA_VS      = vga_vs_q;
  assign VGA_BLANK_N = vga_blank_n_q;
  assign VGA_R       = vga_r_q;
  assign VGA_G       = vga_g_q;
  assign VGA_B       = vga_b_q;
  assign VGA_SYNC_N  = 1'b0;

endmodule
